// File: rtl/motor_pkg.sv
// motor_pkg: shared constants for the motor ramp block -- top-FSM mode codes,
// H-bridge direction codes, per-channel state encoding and the 10-bit speed table.
package motor_pkg;

  // Top-FSM mode codes (IDLE/START/COUNT/FINISH/STOP all command zero duty)
  localparam logic [4:0] MODE_IDLE         = 5'd0;
  localparam logic [4:0] MODE_START        = 5'd1;
  localparam logic [4:0] MODE_COUNT        = 5'd2;
  localparam logic [4:0] MODE_STRAIGHT     = 5'd3;
  localparam logic [4:0] MODE_CHOOSE       = 5'd4;
  localparam logic [4:0] MODE_LEFT         = 5'd5;
  localparam logic [4:0] MODE_RIGHT        = 5'd6;
  localparam logic [4:0] MODE_BACK         = 5'd7;
  localparam logic [4:0] MODE_LITTLE_LEFT  = 5'd8;
  localparam logic [4:0] MODE_LITTLE_RIGHT = 5'd9;
  localparam logic [4:0] MODE_FINISH       = 5'd10;
  localparam logic [4:0] MODE_STOP         = 5'd11;
  localparam logic [4:0] MODE_ERROR        = 5'd31;

  // H-bridge IN pin codes
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  // Per-channel ramp state
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DECEL = 2'd1,
    ST_DEAD  = 2'd2
  } ch_state_e;

  // Speed table in 10-bit units; scaled up when DUTY_W > 10
  localparam logic [9:0] SPD_750 = 10'd750;
  localparam logic [9:0] SPD_740 = 10'd740;
  localparam logic [9:0] SPD_730 = 10'd730;
  localparam logic [9:0] SPD_700 = 10'd700;

endpackage

// File: rtl/motor_ramp_if.sv
// motor_ramp_if: mode command in, duty words / bridge pins / status out.
// master = top FSM side, slave = motor_ramp.
interface motor_ramp_if #(
  parameter int DUTY_W = 10
);
  logic [4:0]        mode;
  logic [DUTY_W-1:0] duty_l;
  logic [DUTY_W-1:0] duty_r;
  logic [1:0]        l_IN;
  logic [1:0]        r_IN;
  logic              busy;
  logic              at_target;

  modport master (output mode, input duty_l, duty_r, l_IN, r_IN, busy, at_target);
  modport slave  (input mode, output duty_l, duty_r, l_IN, r_IN, busy, at_target);
endinterface

// File: rtl/motor_ramp_ch.sv
// motor_ramp_ch: one motor side. Slews duty toward the target at RAMP_STEP per
// tick, decelerates to zero and holds a dead-time before reversing direction.
// Build option MOTOR_BRAKE_EN: bridge pins brake (11) during dead-time and error.
module motor_ramp_ch
  import motor_pkg::*;
#(
  parameter int DUTY_W         = 10,
  parameter int RAMP_STEP      = 10,
  parameter int DEADTIME_TICKS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              err_i,
  input  logic [DUTY_W-1:0] tgt_duty_i,
  input  logic [1:0]        tgt_dir_i,
  output logic [DUTY_W-1:0] duty_o,
  output logic [1:0]        in_o,
  output logic              busy_o,
  output logic              at_tgt_o
);
  localparam int                DEAD_W    = $clog2(DEADTIME_TICKS + 1);
  localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEADTIME_TICKS);

  ch_state_e         state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, ramp_s, decel_s;
  logic [1:0]        dir_q, dir_d, in_q, in_d;
  logic [DEAD_W-1:0] dead_q, dead_d;

  assign decel_s = (duty_q > STEP) ? (duty_q - STEP) : '0;

  // One slew step toward the target, landing exactly on it when within a step
  always_comb begin
    if (tgt_duty_i >= duty_q) begin
      if ((tgt_duty_i - duty_q) <= STEP) ramp_s = tgt_duty_i;
      else                               ramp_s = duty_q + STEP;
    end else begin
      if ((duty_q - tgt_duty_i) <= STEP) ramp_s = tgt_duty_i;
      else                               ramp_s = duty_q - STEP;
    end
  end

  // Channel FSM: error stop overrides everything, otherwise motion only on tick
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    dead_d  = dead_q;
    if (err_i) begin
      state_d = ST_RUN;
      duty_d  = '0;
      dead_d  = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!tick_i)                  state_d = ST_RUN;
          else if (tgt_dir_i == dir_q)  duty_d  = ramp_s;
          else if (duty_q != '0)        state_d = ST_DECEL;
          else begin
            state_d = ST_DEAD;
            dead_d  = DEAD_LOAD;
          end
        end
        ST_DECEL: begin
          // target swung back before we stopped: resume from present duty
          if (tgt_dir_i == dir_q) state_d = ST_RUN;
          else if (tick_i) begin
            duty_d = decel_s;
            if (decel_s == '0) begin
              state_d = ST_DEAD;
              dead_d  = DEAD_LOAD;
            end else begin
              state_d = ST_DECEL;
            end
          end else begin
            state_d = ST_DECEL;
          end
        end
        ST_DEAD: begin
          duty_d = '0;
          if (!tick_i)                      dead_d = dead_q;
          else if (dead_q <= DEAD_W'(1)) begin
            dead_d  = '0;
            dir_d   = tgt_dir_i;
            state_d = ST_RUN;
          end else begin
            dead_d = dead_q - DEAD_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          duty_d  = '0;
        end
      endcase
    end
  end

  // Bridge pin code follows the next state so it changes together with duty
  always_comb begin
`ifdef MOTOR_BRAKE_EN
    if (err_i || (state_d == ST_DEAD)) in_d = DIR_BRAKE;
    else                               in_d = dir_d;
`else
    if (state_d == ST_DEAD) in_d = DIR_COAST;
    else                    in_d = dir_d;
`endif
  end

  // Channel state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      duty_q  <= '0;
      dir_q   <= DIR_FWD;
      dead_q  <= '0;
      in_q    <= DIR_FWD;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      dead_q  <= dead_d;
      in_q    <= in_d;
    end
  end

  assign duty_o   = duty_q;
  assign in_o     = in_q;
  assign busy_o   = (state_q == ST_DECEL) || (state_q == ST_DEAD);
  assign at_tgt_o = (duty_q == tgt_duty_i) && (dir_q == tgt_dir_i);
endmodule

// File: rtl/motor_ramp.sv
// motor_ramp: decodes the top-FSM mode into per-side targets, runs the shared
// ramp prescaler and combines the two channel status flags.
// Build option MOTOR_BRAKE_EN is handled inside motor_ramp_ch.
module motor_ramp
  import motor_pkg::*;
#(
  parameter int DUTY_W         = 10,
  parameter int RAMP_DIV       = 100000,
  parameter int RAMP_STEP      = 10,
  parameter int DEADTIME_TICKS = 5
) (
  input logic         clk,
  input logic         rst,
  motor_ramp_if.slave bus
);
  localparam int               CNT_W    = $clog2(RAMP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_s, err_s;
  logic [DUTY_W-1:0] tgt_l_duty_q, tgt_l_duty_d, tgt_r_duty_q, tgt_r_duty_d;
  logic [1:0]        tgt_l_dir_q, tgt_l_dir_d, tgt_r_dir_q, tgt_r_dir_d;
  logic [DUTY_W-1:0] duty_l_s, duty_r_s;
  logic [1:0]        l_in_s, r_in_s;
  logic              busy_l_s, busy_r_s, at_l_s, at_r_s;
  logic              busy_q, at_target_q;

  function automatic logic [DUTY_W-1:0] scale(input logic [9:0] v);
    return DUTY_W'(v) << (DUTY_W - 10);
  endfunction

  assign tick_s = (cnt_q == CNT_LAST);
  assign err_s  = (bus.mode == MODE_ERROR);

  // Prescaler next count: wrap after the tick cycle
  always_comb begin
    if (tick_s) cnt_d = '0;
    else        cnt_d = cnt_q + CNT_W'(1);
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // Mode table; non-driving modes command zero duty and keep the target direction
  always_comb begin
    tgt_l_duty_d = '0;
    tgt_r_duty_d = '0;
    tgt_l_dir_d  = tgt_l_dir_q;
    tgt_r_dir_d  = tgt_r_dir_q;
    case (bus.mode)
      MODE_STRAIGHT: begin
        tgt_l_duty_d = scale(SPD_750); tgt_l_dir_d = DIR_FWD;
        tgt_r_duty_d = scale(SPD_730); tgt_r_dir_d = DIR_FWD;
      end
      MODE_CHOOSE: begin
        tgt_l_duty_d = scale(SPD_750); tgt_l_dir_d = DIR_FWD;
        tgt_r_duty_d = scale(SPD_750); tgt_r_dir_d = DIR_FWD;
      end
      MODE_LEFT: begin
        tgt_l_duty_d = scale(SPD_750); tgt_l_dir_d = DIR_REV;
        tgt_r_duty_d = scale(SPD_750); tgt_r_dir_d = DIR_FWD;
      end
      MODE_RIGHT: begin
        tgt_l_duty_d = scale(SPD_750); tgt_l_dir_d = DIR_FWD;
        tgt_r_duty_d = scale(SPD_750); tgt_r_dir_d = DIR_REV;
      end
      MODE_BACK: begin
        tgt_l_duty_d = scale(SPD_750); tgt_l_dir_d = DIR_REV;
        tgt_r_duty_d = scale(SPD_740); tgt_r_dir_d = DIR_REV;
      end
      MODE_LITTLE_LEFT: begin
        tgt_l_duty_d = scale(SPD_700); tgt_l_dir_d = DIR_FWD;
        tgt_r_duty_d = scale(SPD_750); tgt_r_dir_d = DIR_FWD;
      end
      MODE_LITTLE_RIGHT: begin
        tgt_l_duty_d = scale(SPD_750); tgt_l_dir_d = DIR_FWD;
        tgt_r_duty_d = scale(SPD_700); tgt_r_dir_d = DIR_FWD;
      end
      MODE_IDLE, MODE_START, MODE_COUNT, MODE_FINISH, MODE_STOP, MODE_ERROR: begin
        tgt_l_dir_d = tgt_l_dir_q;
        tgt_r_dir_d = tgt_r_dir_q;
      end
      default: begin
        tgt_l_dir_d = tgt_l_dir_q;
        tgt_r_dir_d = tgt_r_dir_q;
      end
    endcase
  end

  // Registered targets (one clk behind mode)
  always_ff @(posedge clk) begin
    if (!rst) begin
      tgt_l_duty_q <= '0;
      tgt_r_duty_q <= '0;
      tgt_l_dir_q  <= DIR_FWD;
      tgt_r_dir_q  <= DIR_FWD;
    end else begin
      tgt_l_duty_q <= tgt_l_duty_d;
      tgt_r_duty_q <= tgt_r_duty_d;
      tgt_l_dir_q  <= tgt_l_dir_d;
      tgt_r_dir_q  <= tgt_r_dir_d;
    end
  end

  motor_ramp_ch #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP), .DEADTIME_TICKS(DEADTIME_TICKS)) u_ch_l (
    .clk(clk), .rst(rst), .tick_i(tick_s), .err_i(err_s),
    .tgt_duty_i(tgt_l_duty_q), .tgt_dir_i(tgt_l_dir_q),
    .duty_o(duty_l_s), .in_o(l_in_s), .busy_o(busy_l_s), .at_tgt_o(at_l_s)
  );

  motor_ramp_ch #(.DUTY_W(DUTY_W), .RAMP_STEP(RAMP_STEP), .DEADTIME_TICKS(DEADTIME_TICKS)) u_ch_r (
    .clk(clk), .rst(rst), .tick_i(tick_s), .err_i(err_s),
    .tgt_duty_i(tgt_r_duty_q), .tgt_dir_i(tgt_r_dir_q),
    .duty_o(duty_r_s), .in_o(r_in_s), .busy_o(busy_r_s), .at_tgt_o(at_r_s)
  );

  // Combined status, registered one clk behind channel state
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= 1'b0;
      at_target_q <= 1'b1;
    end else begin
      busy_q      <= busy_l_s | busy_r_s;
      at_target_q <= at_l_s & at_r_s;
    end
  end

  assign bus.duty_l    = duty_l_s;
  assign bus.duty_r    = duty_r_s;
  assign bus.l_IN      = l_in_s;
  assign bus.r_IN      = r_in_s;
  assign bus.busy      = busy_q;
  assign bus.at_target = at_target_q;
endmodule

// File: tb/tb_motor_ramp.sv
// tb_motor_ramp: bench for motor_ramp with RAMP_DIV=4, RAMP_STEP=100,
// DEADTIME_TICKS=2, DUTY_W=10. Expected pin codes follow MOTOR_BRAKE_EN.
module tb_motor_ramp;
  import motor_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  motor_ramp_if #(.DUTY_W(10)) bus ();

  motor_ramp #(.DUTY_W(10), .RAMP_DIV(4), .RAMP_STEP(100), .DEADTIME_TICKS(2)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

`ifdef MOTOR_BRAKE_EN
  localparam int DEAD_IN = 3;
  localparam int ERR_BRAKE = 1;
`else
  localparam int DEAD_IN = 0;
  localparam int ERR_BRAKE = 0;
`endif

  typedef struct {
    logic [4:0] mode;
    int         cycles;
    int         dl;
    int         dr;
    int         lin;
    int         rin;
    int         busy;
    int         at;
  } vec_t;

  vec_t vecs[13];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic [4:0] m, input int dl, input int dr,
                              input int lin, input int rin);
    vec_t v;
    v.mode = m; v.cycles = 120; v.dl = dl; v.dr = dr;
    v.lin = lin; v.rin = rin; v.busy = 0; v.at = 1;
    return v;
  endfunction

  function automatic int err_in(input int dir);
    return (ERR_BRAKE != 0) ? 3 : dir;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // waits for duty_l to move; returns the number of clocks it took
  task automatic wait_l(output int cyc);
    int start;
    start = int'(bus.duty_l);
    cyc = 0;
    while (int'(bus.duty_l) == start && cyc < 40) begin
      step(1);
      cyc++;
    end
    chk("duty_l_change_in_budget", int'(cyc < 40), 1);
  endtask

  task automatic do_reset(input logic [4:0] m);
    bus.mode = m;
    rst = 1'b0;
    step(3);
    rst = 1'b1;
  endtask

  initial begin
    int   cyc;
    int   n;
    vec_t e;

    // ---------------- reset values and first ramp-up ----------------
    bus.mode = MODE_STRAIGHT;
    rst = 1'b0;
    step(3);
    chk("rst_duty_l", int'(bus.duty_l), 0);
    chk("rst_duty_r", int'(bus.duty_r), 0);
    chk("rst_l_IN", int'(bus.l_IN), 2);
    chk("rst_r_IN", int'(bus.r_IN), 2);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_at_target", int'(bus.at_target), 1);

    for (int k = 1; k <= 7; k++) begin
      e = mk(MODE_STRAIGHT, 100 * k, 100 * k, 2, 2);
      exp_q.push_back(e);
    end
    e = mk(MODE_STRAIGHT, 750, 730, 2, 2);
    exp_q.push_back(e);
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wait_l(cyc);
      e = exp_q.pop_front();
      chk("up_duty_l", int'(bus.duty_l), e.dl);
      chk("up_duty_r", int'(bus.duty_r), e.dr);
      chk("up_tick_spacing", cyc, 4);
    end
    chk("up_at_target_lag", int'(bus.at_target), 0);
    step(1);
    chk("up_at_target", int'(bus.at_target), 1);

    // ---------------- reversal STRAIGHT -> BACK ----------------
    step(10);
    bus.mode = MODE_BACK;
    for (int k = 0; k < 8; k++) begin
      wait_l(cyc);
      chk("decel_duty_l", int'(bus.duty_l), (k < 7) ? (650 - 100 * k) : 0);
      if (k > 0) chk("decel_tick_spacing", cyc, 4);
      chk("decel_l_IN", int'(bus.l_IN), (k < 7) ? 2 : DEAD_IN);
      chk("decel_busy", int'(bus.busy), 1);
    end
    n = 0;
    while (int'(bus.l_IN) == DEAD_IN && n < 40) begin
      step(1);
      n++;
      if (int'(bus.l_IN) == DEAD_IN) chk("dead_busy", int'(bus.busy), 1);
    end
    chk("dead_length_clk", n, 8);
    chk("rev_l_IN", int'(bus.l_IN), 1);
    for (int k = 0; k < 8; k++) begin
      wait_l(cyc);
      chk("rev_up_duty_l", int'(bus.duty_l), (k < 7) ? (100 * (k + 1)) : 750);
      chk("rev_up_l_IN", int'(bus.l_IN), 1);
    end
    step(2);
    chk("rev_duty_r", int'(bus.duty_r), 740);
    chk("rev_r_IN", int'(bus.r_IN), 1);
    chk("rev_busy_done", int'(bus.busy), 0);
    chk("rev_at_target", int'(bus.at_target), 1);

    // ---------------- DECEL aborted by LITTLE_LEFT ----------------
    do_reset(MODE_CHOOSE);
    step(100);
    chk("abort_start_duty_l", int'(bus.duty_l), 750);
    bus.mode = MODE_LEFT;
    for (int k = 0; k < 3; k++) begin
      wait_l(cyc);
      chk("abort_decel_duty_l", int'(bus.duty_l), 650 - 100 * k);
      chk("abort_decel_l_IN", int'(bus.l_IN), 2);
    end
    bus.mode = MODE_LITTLE_LEFT;
    for (int k = 0; k < 3; k++) begin
      wait_l(cyc);
      chk("abort_up_duty_l", int'(bus.duty_l), (k < 2) ? (550 + 100 * k) : 700);
      chk("abort_up_spacing", cyc, 4);
      chk("abort_up_l_IN", int'(bus.l_IN), 2);
    end
    step(2);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_at_target", int'(bus.at_target), 1);

    // ---------------- ERROR hard stop ----------------
    do_reset(MODE_CHOOSE);
    step(100);
    chk("err_pre_duty_r", int'(bus.duty_r), 750);
    bus.mode = MODE_ERROR;
    step(1);
    chk("err_duty_l", int'(bus.duty_l), 0);
    chk("err_duty_r", int'(bus.duty_r), 0);
    chk("err_l_IN", int'(bus.l_IN), err_in(2));
    chk("err_r_IN", int'(bus.r_IN), err_in(2));
    chk("err_busy", int'(bus.busy), 0);
    step(6);
    chk("err_hold_duty_l", int'(bus.duty_l), 0);
    chk("err_hold_l_IN", int'(bus.l_IN), err_in(2));
    bus.mode = MODE_CHOOSE;
    step(1);
    chk("err_exit_l_IN", int'(bus.l_IN), 2);
    wait_l(cyc);
    chk("err_exit_duty_l", int'(bus.duty_l), 100);
    chk("err_exit_duty_r", int'(bus.duty_r), 100);

    // ---------------- reset during DEAD ----------------
    do_reset(MODE_CHOOSE);
    step(100);
    bus.mode = MODE_BACK;
    n = 0;
    while (int'(bus.duty_l) != 0 && n < 100) begin
      step(1);
      n++;
    end
    chk("rstdead_reached_zero", int'(n < 100), 1);
    chk("rstdead_in_dead", int'(bus.l_IN), DEAD_IN);
    step(2);
    rst = 1'b0;
    step(1);
    chk("rstdead_duty_l", int'(bus.duty_l), 0);
    chk("rstdead_duty_r", int'(bus.duty_r), 0);
    chk("rstdead_l_IN", int'(bus.l_IN), 2);
    chk("rstdead_r_IN", int'(bus.r_IN), 2);
    chk("rstdead_busy", int'(bus.busy), 0);
    bus.mode = MODE_CHOOSE;
    rst = 1'b1;
    wait_l(cyc);
    chk("rstdead_first_tick", cyc, 4);
    chk("rstdead_up_duty", int'(bus.duty_l), 100);
    chk("rstdead_up_l_IN", int'(bus.l_IN), 2);

    // ---------------- settled-state table ----------------
    vecs[0]  = mk(MODE_STRAIGHT,     750, 730, 2, 2);
    vecs[1]  = mk(MODE_CHOOSE,       750, 750, 2, 2);
    vecs[2]  = mk(MODE_LEFT,         750, 750, 1, 2);
    vecs[3]  = mk(MODE_RIGHT,        750, 750, 2, 1);
    vecs[4]  = mk(MODE_BACK,         750, 740, 1, 1);
    vecs[5]  = mk(MODE_LITTLE_LEFT,  700, 750, 2, 2);
    vecs[6]  = mk(MODE_LITTLE_RIGHT, 750, 700, 2, 2);
    vecs[7]  = mk(MODE_IDLE,         0,   0,   2, 2);
    vecs[8]  = mk(MODE_BACK,         750, 740, 1, 1);
    vecs[9]  = mk(MODE_STOP,         0,   0,   1, 1);
    vecs[10] = mk(5'd20,             0,   0,   1, 1);
    vecs[11] = mk(MODE_ERROR,        0,   0,   err_in(1), err_in(1));
    vecs[12] = mk(MODE_CHOOSE,       750, 750, 2, 2);

    do_reset(MODE_IDLE);
    for (int i = 0; i < 13; i++) begin
      bus.mode = vecs[i].mode;
      exp_q.push_back(vecs[i]);
      step(vecs[i].cycles);
      e = exp_q.pop_front();
      chk($sformatf("tbl%0d_duty_l", i), int'(bus.duty_l), e.dl);
      chk($sformatf("tbl%0d_duty_r", i), int'(bus.duty_r), e.dr);
      chk($sformatf("tbl%0d_l_IN", i), int'(bus.l_IN), e.lin);
      chk($sformatf("tbl%0d_r_IN", i), int'(bus.r_IN), e.rin);
      chk($sformatf("tbl%0d_busy", i), int'(bus.busy), e.busy);
      chk($sformatf("tbl%0d_at_target", i), int'(bus.at_target), e.at);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard time limit so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
